// File: rtl/div_defs.sv
// Shared definitions for the iterative divider.
//   DIV_XLEN : operand/result width (only 32 is supported)
//   op_e     : RV32M divide opcodes as presented on the op port
//   state_e  : divider FSM states
//   negate   : two's complement negation (~x + 1)
//   abs_if   : magnitude of x when en is set and x is negative, else x unchanged
package div_defs;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_SPEC = 2'd3
  } state_e;

  function automatic logic [DIV_XLEN-1:0] negate(input logic [DIV_XLEN-1:0] x);
    return ~x + DIV_XLEN'(1);
  endfunction

  // 32'h8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_XLEN-1:0] abs_if(input logic [DIV_XLEN-1:0] x,
                                                  input logic                en);
    return (en && x[DIV_XLEN-1]) ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem_i / quo_i : current partial remainder and quotient/dividend shift register
//   div_i         : divisor magnitude
//   rem_o / quo_o : values after shifting {rem,quo} left by one and trial-subtracting
module div_step
  import div_defs::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN-1:0] rem_sh;
  logic [XLEN-1:0] quo_sh;
  logic [XLEN:0]   trial;

  // Before the shift, rem holds at most the top k dividend bits after k
  // iterations, so the bit shifted out of rem is always zero.
  always_comb begin
    rem_sh = {rem_i[XLEN-2:0], quo_i[XLEN-1]};
    quo_sh = {quo_i[XLEN-2:0], 1'b0};
    trial  = {1'b0, rem_sh} - {1'b0, div_i};
    if (!trial[XLEN]) begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_sh[XLEN-1:1], 1'b1};
    end else begin
      rem_o = rem_sh;
      quo_o = quo_sh;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   start, op           : request and opcode, sampled only while idle
//   dividend, divisor   : operands, sampled with start
//   busy                : high from the cycle after accept until the done cycle
//   done                : one-cycle pulse, result valid in the same cycle
//   result              : quotient or remainder, held until the next done
// Normal operations take 32 iteration cycles plus one fix-up cycle; divide by
// zero and signed overflow resolve in a single cycle after accept.
module div_unit
  import div_defs::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  op_e             op_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            spec_div0_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic [4:0]      cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic            op_signed;
  logic            is_div0;
  logic            is_ovf;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_comb begin
    op_signed = (op == OP_DIV) || (op == OP_REM);
    is_div0   = (divisor == '0);
    is_ovf    = (op == OP_DIV) && (dividend == INT_MIN) && (divisor == '1);
    quo_fix   = neg_quo_q ? negate(quo_q) : quo_q;
    rem_fix   = neg_rem_q ? negate(rem_q) : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_DIV;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      spec_div0_q <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op_e'(op);
            busy_q <= 1'b1;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (is_div0 || is_ovf) begin
              // Raw operands are kept: the div-by-zero remainder is the
              // dividend exactly as presented.
              state_q     <= ST_SPEC;
              spec_div0_q <= is_div0;
              quo_q       <= dividend;
              div_q       <= divisor;
              neg_quo_q   <= 1'b0;
              neg_rem_q   <= 1'b0;
            end else begin
              state_q     <= ST_CALC;
              spec_div0_q <= 1'b0;
              quo_q       <= abs_if(dividend, op_signed);
              div_q       <= abs_if(divisor, op_signed);
              neg_quo_q   <= op_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
              neg_rem_q   <= op_signed && dividend[XLEN-1];
            end
          end
        end
        ST_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= op_q[1] ? rem_fix : quo_fix;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        ST_SPEC: begin
          if (op_q[1]) result_q <= spec_div0_q ? quo_q : '0;
          else         result_q <= spec_div0_q ? '1 : INT_MIN;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes the expected result and the
// expected done cycle; a negedge monitor pops and compares on every done.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc;
  int          checks;
  int          errors;
  logic [31:0] last_res;

  div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: RV32M semantics with wide signed arithmetic (truncating division).
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = sa / sbv;
      r   = sa % sbv;
      return o[1] ? r[31:0] : q[31:0];
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (o == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle or in its done cycle.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    e.res    = model(o, a, b);
    e.due    = cyc + 1 + (is_special(o, a, b) ? 1 : 33);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
    check("result_hold", result, last_res);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    last_res = e.res;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got=none expected=done within 60 cycles");
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    wait_done();
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got=%h expected=no done", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("done_cycle", cyc, mon_e.due);
        check("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    last_res = 32'd0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, each issued in the previous operation's done cycle.
    run(2'b01, 32'd100, 32'd7);
    run(2'b11, 32'd100, 32'd7);
    run(2'b00, -32'sd7, 32'd2);
    run(2'b10, -32'sd7, 32'd2);
    run(2'b10, 32'd7, -32'sd2);
    run(2'b00, 32'd5, 32'd0);
    run(2'b11, 32'd5, 32'd0);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b10, 32'd5, 32'd0);

    // Extra start pulses at edges 5 and 20 of a busy operation are ignored.
    issue(2'b01, 32'hFFFF_FFFF, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b00; dividend = $urandom; divisor = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b11; dividend = $urandom; divisor = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Randomized operations with biased corner cases.
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          sel;
      ro  = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: begin ro = 2'($urandom_range(0, 1) * 2); ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3: rb = 32'($urandom_range(1, 20)) ^ ({32{$urandom_range(0, 1) == 1}});
        4: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run(ro, ra, rb);
    end

    // Reset during iteration 10 aborts the operation with no done.
    issue(2'b00, 32'd123456, 32'd789);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    last_res = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    run(2'b11, 32'd1000, 32'd33);
    run(2'b00, 32'hFFFF_FF00, 32'd16);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
